// File: rtl/btb_bimodal_if.sv
// Bundles the IF lookup port, the EX/MEM resolution port, flush and perf counters of btb_bimodal.
// Latency: none of its own; it only carries signals.
// Backpressure: none; every port is a per-cycle strobe that is always accepted.
interface btb_bimodal_if #(
    parameter int PERF_W = 32
);
    logic              lookup_en_i;
    logic [31:0]       lookup_pc_i;
    logic              pred_hit_o;
    logic              pred_taken_o;
    logic [31:0]       pred_target_o;

    logic              upd_valid_i;
    logic [31:0]       upd_pc_i;
    logic              upd_taken_i;
    logic [31:0]       upd_target_i;
    logic              upd_pred_taken_i;
    logic [31:0]       upd_pred_target_i;
    logic              mispredict_o;
    logic [31:0]       redirect_pc_o;

    logic              flush_i;
    logic [PERF_W-1:0] perf_branches_o;
    logic [PERF_W-1:0] perf_mispred_o;

    modport master (
        output lookup_en_i, lookup_pc_i,
        output upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        output upd_pred_taken_i, upd_pred_target_i, flush_i,
        input  pred_hit_o, pred_taken_o, pred_target_o,
        input  mispredict_o, redirect_pc_o,
        input  perf_branches_o, perf_mispred_o
    );

    modport slave (
        input  lookup_en_i, lookup_pc_i,
        input  upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        input  upd_pred_taken_i, upd_pred_target_i, flush_i,
        output pred_hit_o, pred_taken_o, pred_target_o,
        output mispredict_o, redirect_pc_o,
        output perf_branches_o, perf_mispred_o
    );
endinterface

// File: rtl/btb_bimodal.sv
// Direct-mapped branch target buffer with saturating direction counters and perf counters.
// Latency: lookup and resolution 0 cycles; table updates visible the cycle after the edge.
// Backpressure: none; one lookup and one resolution are accepted every cycle.
module btb_bimodal #(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int CTR_W   = 2,
    parameter int PERF_W  = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    btb_bimodal_if.slave  bus
);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_MAX >> 1;
    localparam logic [CTR_W-1:0] CTR_WT  = ~CTR_WNT;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [CTR_W-1:0]  ctr_q    [ENTRIES];
    logic [PERF_W-1:0] perf_br_q;
    logic [PERF_W-1:0] perf_mp_q;

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic              lk_hit;
    logic              lk_taken;
    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  up_tag;
    logic              up_hit;
    logic [31:0]       redirect;
    logic              mispredict;
    logic              unused_pred_taken;

    assign lk_idx = bus.lookup_pc_i[IDX_W+1:2];
    assign lk_tag = bus.lookup_pc_i[31:IDX_W+2];
    assign up_idx = bus.upd_pc_i[IDX_W+1:2];
    assign up_tag = bus.upd_pc_i[31:IDX_W+2];

    // The predicted direction travels down the pipe but only the predicted target decides a flush.
    assign unused_pred_taken = bus.upd_pred_taken_i;

    always_comb begin
        lk_hit   = bus.lookup_en_i & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
        lk_taken = lk_hit & ctr_q[lk_idx][CTR_W-1];
        up_hit   = valid_q[up_idx] & (tag_q[up_idx] == up_tag);
        redirect = '0;
        if (bus.upd_valid_i) begin
            redirect = bus.upd_taken_i ? bus.upd_target_i : bus.upd_pc_i + 32'd4;
        end
        mispredict = bus.upd_valid_i & (bus.upd_pred_target_i != redirect);
    end

    assign bus.pred_hit_o      = lk_hit;
    assign bus.pred_taken_o    = lk_taken;
    assign bus.pred_target_o   = !bus.lookup_en_i ? 32'd0 :
                                 lk_taken ? target_q[lk_idx] : bus.lookup_pc_i + 32'd4;
    assign bus.mispredict_o    = mispredict;
    assign bus.redirect_pc_o   = redirect;
    assign bus.perf_branches_o = perf_br_q;
    assign bus.perf_mispred_o  = perf_mp_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            // Perf counters keep counting through a flush.
            if (bus.upd_valid_i) begin
                perf_br_q <= perf_br_q + 1'b1;
                if (mispredict) begin
                    perf_mp_q <= perf_mp_q + 1'b1;
                end
            end

            if (bus.flush_i) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    valid_q[i] <= 1'b0;
                end
            end else if (bus.upd_valid_i) begin
                if (up_hit) begin
                    if (bus.upd_taken_i) begin
                        if (ctr_q[up_idx] != CTR_MAX) begin
                            ctr_q[up_idx] <= ctr_q[up_idx] + 1'b1;
                        end
                        target_q[up_idx] <= bus.upd_target_i;
                    end else if (ctr_q[up_idx] != '0) begin
                        ctr_q[up_idx] <= ctr_q[up_idx] - 1'b1;
                    end
                end else if (bus.upd_taken_i) begin
                    valid_q[up_idx]  <= 1'b1;
                    tag_q[up_idx]    <= up_tag;
                    target_q[up_idx] <= bus.upd_target_i;
                    ctr_q[up_idx]    <= CTR_WT;
                end
            end
        end
    end
endmodule
